audio_arbiter: RTL and testbench
================================

Name: audio_arbiter

Overview:
Shares the board's single square-wave audio pin between the background-music player and short game sound effects: move, merge, win and lose.
- Drives the music player's play-enable, pausing the music while an effect plays.
- Sequences each effect as a short tone list from a small ROM, with priority preemption.
- Resumes the music after a fixed silent gap.
- Sits between the game FSM, the background-music player and the audio output pins.

Parameters:
MS_CYCLES, 100_000, clk cycles per millisecond (100 MHz); overridable for simulation.
GAP_MS, 50, silent milliseconds between effect end and music resume.

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
bgm_enable  in  1  user/game wants background music
bgm_audio  in  1  square wave from the background-music player
sfx_req  in  4  single-cycle request pulses; bit0 move, bit1 merge, bit2 win, bit3 lose
bgm_play  out  1  play-enable to the music player (low = player held in reset)
audio_out  out  1  muxed square wave to the audio pin
aud_sd  out  1  amplifier enable (1 = on)
sfx_busy  out  1  an effect or resume gap is in progress
sfx_id  out  2  id of current/last effect

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset values: all outputs 0, pending=0, state IDLE. Reset wins over any simultaneous request.
- Pending: pending[i] is set on sfx_req[i]=1. Bit i is cleared on entry to LOAD with step 0 for id i. Priority: lose > win > merge > move.
- States:
  - IDLE: if pending≠0, go to LOAD with cur_id = highest pending and step=0.
  - LOAD: ROM read, 1 cycle.
    - If dur==0 or step==4 → RESUME.
    - Else tone counter=0, tone_out=0, ms prescaler and ms count cleared → TONE.
  - TONE: tone counter increments. When counter ≥ half_period−1: counter=0 and tone_out toggles, giving a period of exactly 2·half_period cycles. half_period==0 is a rest (tone_out held 0). After dur·MS_CYCLES cycles: step+1 → LOAD.
  - RESUME: audio silent for GAP_MS·MS_CYCLES cycles → IDLE. If pending≠0 during RESUME → LOAD immediately.
- Preemption: in LOAD, TONE or RESUME, a pending id > cur_id aborts the current effect on that edge. cur_id becomes the new id, step=0, → LOAD.
- Lower or equal pending ids wait and play after the current effect finishes, before the gap completes. A re-request of cur_id while it plays sets pending, so the effect replays once.
- Outputs:
  - sfx_busy = (state≠IDLE).
  - bgm_play = bgm_enable & (state==IDLE).
  - audio_out = IDLE ? (bgm_enable & bgm_audio) : (state==TONE ? tone_out : 0).
  - aud_sd = bgm_enable | sfx_busy.
  - All outputs are registered, 1 cycle after the state/inputs that produce them.
- Latency: pulse in cycle N → pending set at edge N → LOAD at edge N+1. sfx_busy=1 and bgm_play=0 are visible in cycle N+2. TONE is active from edge N+2; tone audio is visible from cycle N+3.
- bgm_enable low: effects still play; audio in IDLE is 0.
- Music restarts from its first note on resume, a consequence of the player holding in reset; this is accepted.
- ROM (100 MHz half-periods / ms), step0..3, dur 0 = end:
  - move: 56818/30.
  - merge: 47755/40, 37908/40.
  - win: 47755/80, 37908/80, 31888/80, 23889/160.
  - lose: 113636/120, 127551/120, 190840/240.

Decomposition:
- Shared package audio_pkg:
  - sfx id constants: SFX_MOVE=0, SFX_MERGE=1, SFX_WIN=2, SFX_LOSE=3.
  - state encoding: IDLE, LOAD, TONE, RESUME.
  - widths: HP_W=20, DUR_W=10, STEP_W=3.
- Sub-module sfx_rom: inputs id[1:0] and step[1:0]; outputs half_period[19:0] and dur_ms[9:0]; registered, 1-cycle read.
- Priority encoder, tone generator and ms prescaler stay inline.

Test Plan:
- Reset mid-TONE (lose playing) → next cycle all outputs 0, pending 0, and a new request in the same cycle as reset is ignored.
- bgm_enable=1, no requests, bgm_audio toggling → audio_out follows bgm_audio delayed 1 cycle; bgm_play=1; aud_sd=1.
- MS_CYCLES=100, sfx_req=0001 at cycle N:
  - bgm_play=0 and sfx_busy=1 from N+2.
  - audio_out toggles every 56818 cycles inside a 3000-cycle tone, so no toggle occurs and it stays 0.
  - After 3000 cycles the block enters RESUME; after 5000 cycles bgm_play=1 again.
- MS_CYCLES=100_000, merge request:
  - first tone period is 95510 cycles, second 75816 cycles.
  - each tone lasts 4,000,000 cycles; sfx_id=1.
- Merge playing, lose pulse at step0 → within 1 cycle LOAD for lose; sfx_id=3; the merge pending bit stays clear and merge does not replay.
- Win playing, move pulse → move is held pending; after win's 4th tone, move plays before RESUME; sfx_busy stays high throughout.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// audio_pkg: shared ids, state encoding and widths for audio_arbiter
// Rev 1.0
// ------------------------------------------------------------------
package audio_pkg;

  localparam int HP_W   = 20;
  localparam int DUR_W  = 10;
  localparam int STEP_W = 3;

  localparam logic [1:0] SFX_MOVE  = 2'd0;
  localparam logic [1:0] SFX_MERGE = 2'd1;
  localparam logic [1:0] SFX_WIN   = 2'd2;
  localparam logic [1:0] SFX_LOSE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    TONE   = 2'd2,
    RESUME = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/audio_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// audio_arbiter_if: game/music/pin side signals of the audio arbiter
// Rev 1.0
// ------------------------------------------------------------------
interface audio_arbiter_if;

  logic       bgm_enable;
  logic       bgm_audio;
  logic [3:0] sfx_req;
  logic       bgm_play;
  logic       audio_out;
  logic       aud_sd;
  logic       sfx_busy;
  logic [1:0] sfx_id;

  modport master (
    output bgm_enable, bgm_audio, sfx_req,
    input  bgm_play, audio_out, aud_sd, sfx_busy, sfx_id
  );

  modport slave (
    input  bgm_enable, bgm_audio, sfx_req,
    output bgm_play, audio_out, aud_sd, sfx_busy, sfx_id
  );

endinterface
`default_nettype wire

// File: rtl/audio_arbiter_sfx_rom.sv
`default_nettype none
// ------------------------------------------------------------------
// sfx_rom: tone list per effect (half-period in clk cycles, length ms)
// Rev 1.0
// ------------------------------------------------------------------
module sfx_rom
  import audio_pkg::*;
(
  input  logic             clk,
  input  logic [1:0]       id_i,
  input  logic [1:0]       step_i,
  output logic [HP_W-1:0]  half_period_o,
  output logic [DUR_W-1:0] dur_ms_o
);

  logic [HP_W-1:0]  hp_d, hp_q;
  logic [DUR_W-1:0] dur_d, dur_q;

  // dur 0 marks the end of an effect's tone list
  always_comb begin
    hp_d  = '0;
    dur_d = '0;
    case ({id_i, step_i})
      {SFX_MOVE,  2'd0}: begin hp_d = 20'd56818;  dur_d = 10'd30;  end
      {SFX_MERGE, 2'd0}: begin hp_d = 20'd47755;  dur_d = 10'd40;  end
      {SFX_MERGE, 2'd1}: begin hp_d = 20'd37908;  dur_d = 10'd40;  end
      {SFX_WIN,   2'd0}: begin hp_d = 20'd47755;  dur_d = 10'd80;  end
      {SFX_WIN,   2'd1}: begin hp_d = 20'd37908;  dur_d = 10'd80;  end
      {SFX_WIN,   2'd2}: begin hp_d = 20'd31888;  dur_d = 10'd80;  end
      {SFX_WIN,   2'd3}: begin hp_d = 20'd23889;  dur_d = 10'd160; end
      {SFX_LOSE,  2'd0}: begin hp_d = 20'd113636; dur_d = 10'd120; end
      {SFX_LOSE,  2'd1}: begin hp_d = 20'd127551; dur_d = 10'd120; end
      {SFX_LOSE,  2'd2}: begin hp_d = 20'd190840; dur_d = 10'd240; end
      default:           begin hp_d = '0;         dur_d = '0;      end
    endcase
  end

  always_ff @(posedge clk) begin
    hp_q  <= hp_d;
    dur_q <= dur_d;
  end

  assign half_period_o = hp_q;
  assign dur_ms_o      = dur_q;

endmodule
`default_nettype wire

// File: rtl/audio_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// audio_arbiter: shares one square-wave pin between music and effects
// Rev 1.0
// ------------------------------------------------------------------
module audio_arbiter
  import audio_pkg::*;
#(
  parameter int MS_CYCLES = 100_000,
  parameter int GAP_MS    = 50
) (
  input  logic            clk,
  input  logic            reset,
  audio_arbiter_if.slave  bus
);

  localparam int               PRE_W    = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(MS_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);

  state_e            state_q, state_d;
  logic [3:0]        pending_q, pending_d;
  logic [1:0]        cur_id_q, cur_id_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [HP_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic              tone_out_q, tone_out_d;
  logic [PRE_W-1:0]  ms_pre_q, ms_pre_d;
  logic [DUR_W-1:0]  ms_cnt_q, ms_cnt_d;

  logic       bgm_play_q, audio_out_q, aud_sd_q, sfx_busy_q;
  logic [1:0] sfx_id_q;

  logic [HP_W-1:0]  hp;
  logic [DUR_W-1:0] dur;
  logic [1:0]       hi_id;
  logic             pend_any, preempt, start, ms_tick;

  // ROM is addressed with next-state values so its data is ready in LOAD
  sfx_rom u_rom (
    .clk           (clk),
    .id_i          (cur_id_d),
    .step_i        (step_d[1:0]),
    .half_period_o (hp),
    .dur_ms_o      (dur)
  );

  always_comb begin
    hi_id = SFX_MOVE;
    if (pending_q[3])      hi_id = SFX_LOSE;
    else if (pending_q[2]) hi_id = SFX_WIN;
    else if (pending_q[1]) hi_id = SFX_MERGE;
  end

  assign pend_any = |pending_q;
  assign preempt  = pend_any && (hi_id > cur_id_q);
  assign ms_tick  = (ms_pre_q == PRE_MAX);

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | bus.sfx_req;
    cur_id_d   = cur_id_q;
    step_d     = step_q;
    tone_cnt_d = tone_cnt_q;
    tone_out_d = tone_out_q;
    ms_pre_d   = ms_pre_q;
    ms_cnt_d   = ms_cnt_q;
    start      = 1'b0;
    case (state_q)
      IDLE: start = pend_any;
      LOAD: begin
        if (preempt) begin
          start = 1'b1;
        end else begin
          state_d  = (step_q == STEP_W'(4) || dur == '0) ? RESUME : TONE;
          tone_cnt_d = '0;
          tone_out_d = 1'b0;
          ms_pre_d   = '0;
          ms_cnt_d   = '0;
        end
      end
      TONE: begin
        if (preempt) begin
          start = 1'b1;
        end else begin
          if (hp == '0) begin
            tone_cnt_d = '0;
            tone_out_d = 1'b0;
          end else if (tone_cnt_q >= hp - HP_W'(1)) begin
            tone_cnt_d = '0;
            tone_out_d = ~tone_out_q;
          end else begin
            tone_cnt_d = tone_cnt_q + HP_W'(1);
          end
          ms_pre_d = ms_tick ? '0 : ms_pre_q + PRE_W'(1);
          if (ms_tick) begin
            ms_cnt_d = ms_cnt_q + DUR_W'(1);
            if (ms_cnt_q == dur - DUR_W'(1)) begin
              state_d = LOAD;
              step_d  = step_q + STEP_W'(1);
            end
          end
        end
      end
      RESUME: begin
        if (pend_any) begin
          start = 1'b1;
        end else begin
          ms_pre_d = ms_tick ? '0 : ms_pre_q + PRE_W'(1);
          if (ms_tick) begin
            ms_cnt_d = ms_cnt_q + DUR_W'(1);
            if (ms_cnt_q == GAP_LAST) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d   = LOAD;
      cur_id_d  = hi_id;
      step_d    = '0;
      pending_d = (pending_q & ~(4'b0001 << hi_id)) | bus.sfx_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      cur_id_q    <= '0;
      step_q      <= '0;
      tone_cnt_q  <= '0;
      tone_out_q  <= 1'b0;
      ms_pre_q    <= '0;
      ms_cnt_q    <= '0;
      bgm_play_q  <= 1'b0;
      audio_out_q <= 1'b0;
      aud_sd_q    <= 1'b0;
      sfx_busy_q  <= 1'b0;
      sfx_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cur_id_q    <= cur_id_d;
      step_q      <= step_d;
      tone_cnt_q  <= tone_cnt_d;
      tone_out_q  <= tone_out_d;
      ms_pre_q    <= ms_pre_d;
      ms_cnt_q    <= ms_cnt_d;
      bgm_play_q  <= bus.bgm_enable & (state_d == IDLE);
      audio_out_q <= (state_d == IDLE) ? (bus.bgm_enable & bus.bgm_audio)
                                       : ((state_d == TONE) & tone_out_d);
      aud_sd_q    <= bus.bgm_enable | (state_d != IDLE);
      sfx_busy_q  <= (state_d != IDLE);
      sfx_id_q    <= cur_id_d;
    end
  end

  assign bus.bgm_play  = bgm_play_q;
  assign bus.audio_out = audio_out_q;
  assign bus.aud_sd    = aud_sd_q;
  assign bus.sfx_busy  = sfx_busy_q;
  assign bus.sfx_id    = sfx_id_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_audio_arbiter: directed checks of music mux, effects and preemption
// Rev 1.0
// ------------------------------------------------------------------
module tb_audio_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A runs short milliseconds; instance B is slow enough to reach a toggle
  audio_arbiter_if bus_a ();
  audio_arbiter_if bus_b ();

  audio_arbiter #(.MS_CYCLES(10), .GAP_MS(50)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  audio_arbiter #(.MS_CYCLES(1200), .GAP_MS(50)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] outs_a();
    return {bus_a.bgm_play, bus_a.audio_out, bus_a.aud_sd, bus_a.sfx_busy, bus_a.sfx_id};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    int         glitch;
    int         qb;

    reset            = 1'b1;
    bus_a.bgm_enable = 1'b0;
    bus_a.bgm_audio  = 1'b0;
    bus_a.sfx_req    = 4'd0;
    bus_b.bgm_enable = 1'b0;
    bus_b.bgm_audio  = 1'b0;
    bus_b.sfx_req    = 4'd0;
    step_n(2);
    check("reset_outs", outs_a(), 6'b0);

    // music passthrough, one cycle late
    reset            = 1'b0;
    bus_a.bgm_enable = 1'b1;
    step_n(1);
    pat = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      bus_a.bgm_audio = pat[i];
      step_n(1);
      check("bgm_follow", bus_a.audio_out, pat[i]);
    end
    check("bgm_play_idle", bus_a.bgm_play, 1'b1);
    check("aud_sd_idle", bus_a.aud_sd, 1'b1);
    bus_a.bgm_audio = 1'b0;

    // reset while lose is in its first tone, with a request on the reset edge
    bus_a.sfx_req = 4'b1000;
    step_n(1);
    bus_a.sfx_req = 4'd0;
    step_n(1);
    check("lose_start", {bus_a.sfx_busy, bus_a.bgm_play, bus_a.sfx_id}, {1'b1, 1'b0, 2'd3});
    step_n(20);
    check("lose_mid", bus_a.sfx_busy, 1'b1);
    reset         = 1'b1;
    bus_a.sfx_req = 4'b1000;
    step_n(1);
    check("reset_mid_tone", outs_a(), 6'b0);
    reset         = 1'b0;
    bus_a.sfx_req = 4'd0;
    step_n(1);
    check("post_reset_idle", {bus_a.bgm_play, bus_a.sfx_busy}, 2'b10);
    step_n(3);
    check("post_reset_no_pend", bus_a.sfx_busy, 1'b0);

    // instance B: merge request, first toggle checked at the end
    bus_b.sfx_req = 4'b0010;
    step_n(1);
    qb            = cyc;
    bus_b.sfx_req = 4'd0;

    // move: 300-cycle tone, no toggle, 500-cycle gap
    bus_a.sfx_req = 4'b0001;
    step_n(1);
    bus_a.sfx_req = 4'd0;
    step_n(1);
    check("move_busy", {bus_a.sfx_busy, bus_a.bgm_play, bus_a.sfx_id}, {1'b1, 1'b0, 2'd0});
    glitch = 0;
    for (int i = 0; i < 801; i++) begin
      step_n(1);
      if (!bus_a.sfx_busy || bus_a.audio_out || bus_a.bgm_play) glitch++;
    end
    check("move_hold", glitch, 0);
    step_n(1);
    check("move_done", {bus_a.sfx_busy, bus_a.bgm_play, bus_a.audio_out}, 3'b010);

    // merge preempted by lose; merge must not replay
    bus_a.sfx_req = 4'b0010;
    step_n(1);
    bus_a.sfx_req = 4'd0;
    step_n(2);
    check("merge_id", bus_a.sfx_id, 2'd1);
    bus_a.sfx_req = 4'b1000;
    step_n(1);
    bus_a.sfx_req = 4'd0;
    check("pre_preempt_id", bus_a.sfx_id, 2'd1);
    step_n(1);
    check("preempt_id", {bus_a.sfx_busy, bus_a.sfx_id}, {1'b1, 2'd3});
    glitch = 0;
    for (int i = 0; i < 5303; i++) begin
      step_n(1);
      if (!bus_a.sfx_busy || bus_a.sfx_id != 2'd3) glitch++;
    end
    check("lose_hold", glitch, 0);
    step_n(1);
    check("lose_done", {bus_a.sfx_busy, bus_a.bgm_play, bus_a.sfx_id}, {1'b0, 1'b1, 2'd3});

    // win with move queued behind it
    bus_a.sfx_req = 4'b0100;
    step_n(1);
    bus_a.sfx_req = 4'd0;
    step_n(10);
    bus_a.sfx_req = 4'b0001;
    step_n(1);
    bus_a.sfx_req = 4'd0;
    check("win_id", {bus_a.sfx_busy, bus_a.sfx_id}, {1'b1, 2'd2});
    glitch = 0;
    for (int i = 0; i < 3995; i++) begin
      step_n(1);
      if (!bus_a.sfx_busy || bus_a.sfx_id != 2'd2) glitch++;
    end
    check("win_hold", glitch, 0);
    step_n(1);
    check("queued_move_id", {bus_a.sfx_busy, bus_a.sfx_id}, {1'b1, 2'd0});
    glitch = 0;
    for (int i = 0; i < 801; i++) begin
      step_n(1);
      if (!bus_a.sfx_busy || bus_a.bgm_play) glitch++;
    end
    check("queued_move_hold", glitch, 0);
    step_n(1);
    check("win_move_done", {bus_a.sfx_busy, bus_a.bgm_play}, 2'b01);

    // instance B: merge tone 0 rises after 47755 tone cycles, lasts 48000
    while (cyc < qb + 47756) step_n(1);
    check("b_status", {bus_b.bgm_play, bus_b.aud_sd, bus_b.sfx_busy, bus_b.sfx_id},
          {1'b0, 1'b1, 1'b1, 2'd1});
    check("b_before_toggle", bus_b.audio_out, 1'b0);
    step_n(1);
    check("b_toggle", bus_b.audio_out, 1'b1);
    while (cyc < qb + 48001) step_n(1);
    check("b_tone_last", bus_b.audio_out, 1'b1);
    step_n(1);
    check("b_tone_end", bus_b.audio_out, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
